// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register file write-back path
//
// Purpose: register file geometry, the write-back request record and the
// requester identifiers used by the arbiter and its queues.
// Ports: none (package).
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    SRC_A,
    SRC_B
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - bus bundle between write-back sources, regfile and decode
//
// Purpose: groups the two requester handshakes, the regfile write port,
// the hazard query pair and the idle flag.
// Ports (slave = arbiter side):
//   a_valid/a_ready/a_dest/a_data   ALU write-back request
//   b_valid/b_ready/b_dest/b_data   load write-back request
//   reg_write_en/dest/data          regfile write port
//   q_addr_1/2 -> q_pending_1/2     hazard query
//   idle                            nothing queued or staged
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                  a_valid;
  logic                  a_ready;
  logic [REG_ADDR_W-1:0] a_dest;
  logic [XLEN-1:0]       a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_dest;
  logic [XLEN-1:0]       b_data;
  logic                  reg_write_en;
  logic [REG_ADDR_W-1:0] reg_write_dest;
  logic [XLEN-1:0]       reg_write_data;
  logic [REG_ADDR_W-1:0] q_addr_1;
  logic [REG_ADDR_W-1:0] q_addr_2;
  logic                  q_pending_1;
  logic                  q_pending_2;
  logic                  idle;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, q_addr_1, q_addr_2,
    input  a_ready, b_ready, reg_write_en, reg_write_dest, reg_write_data,
           q_pending_1, q_pending_2, idle
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, q_addr_1, q_addr_2,
    output a_ready, b_ready, reg_write_en, reg_write_dest, reg_write_data,
           q_pending_1, q_pending_2, idle
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// rtl/regfile_wb_arbiter_fifo.sv - per-requester write-back queue
//
// Purpose: DEPTH-entry FIFO of write-back requests with all live entries
// visible for the hazard compare.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_req      append an entry (ignored when full)
//   pop                 drop the head (ignored when empty)
//   head                oldest entry
//   full, empty         occupancy flags from the registered count
//   entries             raw storage, indexed by slot
//   entry_valid         per-slot flag: slot holds a queued entry
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  wb_req_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic                push_en;
  logic                pop_en;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // A slot is live when its distance from the read pointer (mod DEPTH) is
  // below the occupancy.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the single regfile write port
//
// Purpose: queues ALU and load write-backs, grants one per cycle round-robin
// into a registered write stage, and flags in-flight destinations for decode.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        regfile_wb_arbiter_if.slave (requesters, write port, hazard query, idle)
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t               a_in, b_in, a_head, b_head, grant_req;
  wb_req_t [DEPTH-1:0]   a_ent, b_ent;
  logic    [DEPTH-1:0]   a_vld, b_vld;
  logic                  a_full, a_empty, b_full, b_empty;
  logic                  grant_a, grant_b;
  wb_src_e               last_grant;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_dest;
  logic [XLEN-1:0]       wr_data;
  logic                  hit_1, hit_2;

  assign a_in = '{dest: bus.a_dest, data: bus.a_data};
  assign b_in = '{dest: bus.b_dest, data: bus.b_data};

  // Ready comes straight from the registered count; a full queue stays
  // not-ready even in a cycle where it is being popped.
  assign bus.a_ready = !a_full;
  assign bus.b_ready = !b_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst),
    .push(bus.a_valid), .push_req(a_in), .pop(grant_a),
    .head(a_head), .full(a_full), .empty(a_empty),
    .entries(a_ent), .entry_valid(a_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst),
    .push(bus.b_valid), .push_req(b_in), .pop(grant_b),
    .head(b_head), .full(b_full), .empty(b_empty),
    .entries(b_ent), .entry_valid(b_vld)
  );

  // On a tie the requester that did not win last time goes first.
  assign grant_a   = !a_empty && (b_empty || last_grant == SRC_B);
  assign grant_b   = !b_empty && !grant_a;
  assign grant_req = grant_a ? a_head : b_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_B;
      wr_en      <= 1'b0;
      wr_dest    <= '0;
      wr_data    <= '0;
    end else if (grant_a || grant_b) begin
      // r0 writes are drained from the queue but never drive the port.
      wr_en      <= (grant_req.dest != '0);
      wr_dest    <= grant_req.dest;
      wr_data    <= grant_req.data;
      last_grant <= grant_a ? SRC_A : SRC_B;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  assign bus.reg_write_en   = wr_en;
  assign bus.reg_write_dest = wr_dest;
  assign bus.reg_write_data = wr_data;

  always_comb begin
    hit_1 = wr_en && (wr_dest == bus.q_addr_1);
    hit_2 = wr_en && (wr_dest == bus.q_addr_2);
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i] && a_ent[i].dest == bus.q_addr_1) hit_1 = 1'b1;
      if (b_vld[i] && b_ent[i].dest == bus.q_addr_1) hit_1 = 1'b1;
      if (a_vld[i] && a_ent[i].dest == bus.q_addr_2) hit_2 = 1'b1;
      if (b_vld[i] && b_ent[i].dest == bus.q_addr_2) hit_2 = 1'b1;
    end
  end

  assign bus.q_pending_1 = hit_1 && (bus.q_addr_1 != '0);
  assign bus.q_pending_2 = hit_2 && (bus.q_addr_2 != '0);
  assign bus.idle        = a_empty && b_empty && !wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        bv;
    logic [4:0]  bd;
    logic [31:0] bdat;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        ar;
    logic        br;
    logic        en;
    logic        chk_dd;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        p1;
    logic        p2;
    logic        idle;
  } vec_t;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  wr_t  wlog[$];
  vec_t vecs[16];

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and log any regfile write.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.reg_write_en === 1'b1)
      wlog.push_back('{dest: bus.reg_write_dest, data: bus.reg_write_data, cyc: cyc});
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic bv, input logic [4:0] bd, input logic [31:0] bdat);
    bus.a_valid = av; bus.a_dest = ad; bus.a_data = adat;
    bus.b_valid = bv; bus.b_dest = bd; bus.b_data = bdat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    logic acc_a, acc_b;

    //        rst av ad    adat           bv bd    bdat    q1    q2     ar br en dd dest  data           p1 p2 idle
    vecs[0]  = '{1, 1, 5'd1, 32'hAAAA,     1, 5'd2, 32'hBBBB, 5'd1, 5'd2, 1, 1, 0, 1, 5'd0, 32'h0,        0, 0, 1};
    vecs[1]  = '{1, 1, 5'd1, 32'hAAAA,     1, 5'd2, 32'hBBBB, 5'd1, 5'd2, 1, 1, 0, 1, 5'd0, 32'h0,        0, 0, 1};
    vecs[2]  = '{0, 1, 5'd3, 32'h11,       1, 5'd4, 32'h22,   5'd3, 5'd4, 1, 1, 0, 1, 5'd0, 32'h0,        1, 1, 0};
    vecs[3]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd4, 1, 1, 1, 1, 5'd3, 32'h11,       1, 1, 0};
    vecs[4]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd4, 1, 1, 1, 1, 5'd4, 32'h22,       0, 1, 0};
    vecs[5]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd4, 1, 1, 0, 1, 5'd4, 32'h22,       0, 0, 1};
    vecs[6]  = '{0, 1, 5'd6, 32'h66,       1, 5'd7, 32'h77,   5'd6, 5'd7, 1, 1, 0, 1, 5'd4, 32'h22,       1, 1, 0};
    vecs[7]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd6, 5'd7, 1, 1, 1, 1, 5'd6, 32'h66,       1, 1, 0};
    vecs[8]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd6, 5'd7, 1, 1, 1, 1, 5'd7, 32'h77,       0, 1, 0};
    vecs[9]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd6, 5'd7, 1, 1, 0, 1, 5'd7, 32'h77,       0, 0, 1};
    vecs[10] = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    5'd5, 5'd0, 1, 1, 0, 1, 5'd7, 32'h77,       1, 0, 0};
    vecs[11] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd5, 5'd0, 1, 1, 1, 1, 5'd5, 32'hDEADBEEF, 1, 0, 0};
    vecs[12] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd5, 5'd0, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 1};
    vecs[13] = '{0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,    5'd0, 5'd5, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0};
    vecs[14] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 32'h0,        0, 0, 1};
    vecs[15] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 32'h0,        0, 0, 1};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.q_addr_1 = '0;
    bus.q_addr_2 = '0;

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].bv, vecs[i].bd, vecs[i].bdat);
      bus.q_addr_1 = vecs[i].q1;
      bus.q_addr_2 = vecs[i].q2;
      step();
      chk($sformatf("v%0d a_ready", i), 32'(bus.a_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d b_ready", i), 32'(bus.b_ready), 32'(vecs[i].br));
      chk($sformatf("v%0d write_en", i), 32'(bus.reg_write_en), 32'(vecs[i].en));
      if (vecs[i].chk_dd) begin
        chk($sformatf("v%0d write_dest", i), 32'(bus.reg_write_dest), 32'(vecs[i].dest));
        chk($sformatf("v%0d write_data", i), bus.reg_write_data, vecs[i].data);
      end
      chk($sformatf("v%0d pending_1", i), 32'(bus.q_pending_1), 32'(vecs[i].p1));
      chk($sformatf("v%0d pending_2", i), 32'(bus.q_pending_2), 32'(vecs[i].p2));
      chk($sformatf("v%0d idle", i), 32'(bus.idle), 32'(vecs[i].idle));
    end

    // Backpressure: both sources push continuously until 8 each are accepted.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    wlog.delete();
    na = 0;
    nb = 0;
    for (int c = 0; c < 40 && (na < 8 || nb < 8); c++) begin
      drive(na < 8, 5'(16 + na), 32'hA000_0000 + 32'(na),
            nb < 8, 5'(24 + nb), 32'hB000_0000 + 32'(nb));
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      step();
      if (acc_a) na++;
      if (acc_b) nb++;
      if (c == 1) begin
        chk("bp a_ready after edge 2", 32'(bus.a_ready), 32'd1);
        chk("bp b_ready after edge 2", 32'(bus.b_ready), 32'd0);
      end
      if (c == 2) begin
        chk("bp a_ready after edge 3", 32'(bus.a_ready), 32'd0);
        chk("bp b_ready after edge 3", 32'(bus.b_ready), 32'd1);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) step();
    chk("bp accepted A", 32'(na), 32'd8);
    chk("bp accepted B", 32'(nb), 32'd8);
    chk("bp write count", 32'(wlog.size()), 32'd16);
    for (int k = 0; k < wlog.size() && k < 16; k++) begin
      chk($sformatf("bp w%0d dest", k), 32'(wlog[k].dest),
          (k % 2 == 0) ? 32'(16 + k / 2) : 32'(24 + k / 2));
      chk($sformatf("bp w%0d data", k), wlog[k].data,
          (k % 2 == 0) ? 32'hA000_0000 + 32'(k / 2) : 32'hB000_0000 + 32'(k / 2));
      chk($sformatf("bp w%0d back-to-back", k), 32'(wlog[k].cyc - wlog[0].cyc), 32'(k));
    end
    chk("bp idle after drain", 32'(bus.idle), 32'd1);

    // Reset mid-operation discards queued and staged writes.
    bus.q_addr_1 = 5'd9;
    bus.q_addr_2 = 5'd10;
    drive(1, 5'd9, 32'h91, 1, 5'd10, 32'hA1);
    step();
    drive(1, 5'd9, 32'h92, 1, 5'd10, 32'hA2);
    step();
    chk("mid staged write_en", 32'(bus.reg_write_en), 32'd1);
    chk("mid b_ready before reset", 32'(bus.b_ready), 32'd0);
    chk("mid pending before reset", 32'(bus.q_pending_2), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid write_en after reset", 32'(bus.reg_write_en), 32'd0);
    chk("mid idle after reset", 32'(bus.idle), 32'd1);
    chk("mid a_ready after reset", 32'(bus.a_ready), 32'd1);
    chk("mid b_ready after reset", 32'(bus.b_ready), 32'd1);
    chk("mid pending_1 after reset", 32'(bus.q_pending_1), 32'd0);
    chk("mid pending_2 after reset", 32'(bus.q_pending_2), 32'd0);
    wlog.delete();
    for (int c = 0; c < 5; c++) step();
    chk("mid no writes after reset", 32'(wlog.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
